// File: rtl/pkg_sfrs_definition.sv
// Shared SFR-level types for the timer peripheral: counting modes and FSM states.
package pkg_sfrs_definition;

  typedef enum logic [1:0] {
    FREE_RUN = 2'b00,
    PERIODIC = 2'b01,
    ONE_SHOT = 2'b10,
    RSVD     = 2'b11
  } tmr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } tmr_state_e;

endpackage

// File: rtl/tmr_prescaler.sv
// Programmable prescaler: divides enabled cycles by (psc+1) and emits a tick.
module tmr_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_q;
  logic [PSC_W-1:0] psc_cnt_d;

  // >= lets a lowered psc take effect on the very next enabled cycle
  assign tick = en & (psc_cnt_q >= psc);

  // prescaler count next-state
  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (clr) begin
      psc_cnt_d = {PSC_W{1'b0}};
    end else if (tick) begin
      psc_cnt_d = {PSC_W{1'b0}};
    end else if (en) begin
      psc_cnt_d = psc_cnt_q + PSC_W'(1);
    end else begin
      psc_cnt_d = psc_cnt_q;
    end
  end

  // prescaler count register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      psc_cnt_q <= {PSC_W{1'b0}};
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/timer_nbit_v2.sv
// N-bit general-purpose timer with prescaler, free-run/periodic/one-shot modes,
// NUM_CMP compare channels, one-cycle event pulses and sticky flags.
module timer_nbit_v2
  import pkg_sfrs_definition::*;
#(
  parameter int N       = 32,
  parameter int NUM_CMP = 2,
  parameter int PSC_W   = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 sys_clk_en,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [N-1:0]         ld_val,
  input  logic [1:0]           mode,
  input  logic [N-1:0]         period,
  input  logic [PSC_W-1:0]     psc,
  input  logic [NUM_CMP*N-1:0] cmp_val,
  input  logic [NUM_CMP-1:0]   cmp_en,
  input  logic [NUM_CMP:0]     flag_clr,
  output logic [N-1:0]         cnt,
  output logic                 running,
  output logic [NUM_CMP-1:0]   cmp_event,
  output logic                 wrap_event,
  output logic [NUM_CMP-1:0]   cmp_flag,
  output logic                 wrap_flag
);

  tmr_state_e         state_q, state_d;
  logic [N-1:0]       cnt_q, cnt_d;
  logic               wrap_event_q, wrap_event_d;
  logic               wrap_flag_q, wrap_flag_d;
  logic [NUM_CMP-1:0] cmp_event_q, cmp_event_d;
  logic [NUM_CMP-1:0] cmp_flag_q, cmp_flag_d;

  logic               psc_en_s;
  logic               psc_tick_s;
  logic               tick_s;
  logic [N-1:0]       cnt_inc_s;
  logic [N-1:0]       cnt_tick_s;
  logic               wrap_s;
  logic               term_s;
  logic [NUM_CMP-1:0] cmp_hit_s;

  assign psc_en_s = (state_q == RUN) & sys_clk_en & ~stop;

  tmr_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (psc_en_s),
    .clr     (clr | ld),
    .psc     (psc),
    .tick    (psc_tick_s)
  );

  // Higher-priority pulses swallow the count tick of the same cycle.
  assign tick_s    = psc_tick_s & ~clr & ~ld & ~stop;
  assign cnt_inc_s = cnt_q + N'(1);

  // count value a tick would produce, plus wrap/terminal qualifiers
  always_comb begin
    cnt_tick_s = cnt_inc_s;
    wrap_s     = 1'b0;
    term_s     = 1'b0;
    case (tmr_mode_e'(mode))
      PERIODIC: begin
        if (cnt_q == period) begin
          cnt_tick_s = {N{1'b0}};
          wrap_s     = 1'b1;
        end else begin
          cnt_tick_s = cnt_inc_s;
          wrap_s     = (cnt_q == {N{1'b1}});
        end
      end
      ONE_SHOT: begin
        // terminal as soon as the displayed count would equal period
        if ((cnt_q == period) || (cnt_inc_s == period)) begin
          cnt_tick_s = period;
          wrap_s     = 1'b1;
          term_s     = 1'b1;
        end else begin
          cnt_tick_s = cnt_inc_s;
          wrap_s     = (cnt_q == {N{1'b1}});
        end
      end
      default: begin
        cnt_tick_s = cnt_inc_s;
        wrap_s     = (cnt_q == {N{1'b1}});
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
    assign cmp_hit_s[i] = cmp_en[i] & (cnt_tick_s == cmp_val[i*N +: N]);
  end

  // FSM next state, counter next value, events and flags
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
    end else if (tick_s && term_s) begin
      state_d = DONE;
    end else begin
      state_d = state_q;
    end

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {N{1'b0}};
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (start && !stop && (state_q == DONE)) begin
      cnt_d = {N{1'b0}};
    end else if (tick_s) begin
      cnt_d = cnt_tick_s;
    end else begin
      cnt_d = cnt_q;
    end

    wrap_event_d = tick_s & wrap_s;
    cmp_event_d  = cmp_hit_s & {NUM_CMP{tick_s}};
    wrap_flag_d  = wrap_event_d | (wrap_flag_q & ~flag_clr[NUM_CMP]);
    cmp_flag_d   = cmp_event_d | (cmp_flag_q & ~flag_clr[NUM_CMP-1:0]);
  end

  // state, count, event and flag registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= {N{1'b0}};
      wrap_event_q <= 1'b0;
      wrap_flag_q  <= 1'b0;
      cmp_event_q  <= {NUM_CMP{1'b0}};
      cmp_flag_q   <= {NUM_CMP{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wrap_event_q <= wrap_event_d;
      wrap_flag_q  <= wrap_flag_d;
      cmp_event_q  <= cmp_event_d;
      cmp_flag_q   <= cmp_flag_d;
    end
  end

  assign cnt        = cnt_q;
  assign running    = (state_q == RUN);
  assign wrap_event = wrap_event_q;
  assign wrap_flag  = wrap_flag_q;
  assign cmp_event  = cmp_event_q;
  assign cmp_flag   = cmp_flag_q;

endmodule

// File: tb/tb_timer_nbit_v2.sv
// Directed self-checking bench for timer_nbit_v2 with hand-computed expectations.
module tb_timer_nbit_v2;

  localparam int N       = 32;
  localparam int NUM_CMP = 2;
  localparam int PSC_W   = 8;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b1;
  logic                 sys_clk_en = 1'b1;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic                 clr = 1'b0;
  logic                 ld = 1'b0;
  logic [N-1:0]         ld_val = '0;
  logic [1:0]           mode = 2'b00;
  logic [N-1:0]         period = '0;
  logic [PSC_W-1:0]     psc = '0;
  logic [NUM_CMP*N-1:0] cmp_val = '0;
  logic [NUM_CMP-1:0]   cmp_en = '0;
  logic [NUM_CMP:0]     flag_clr = '0;
  logic [N-1:0]         cnt;
  logic                 running;
  logic [NUM_CMP-1:0]   cmp_event;
  logic                 wrap_event;
  logic [NUM_CMP-1:0]   cmp_flag;
  logic                 wrap_flag;

  int n_checks = 0;
  int n_errors = 0;

  timer_nbit_v2 #(.N(N), .NUM_CMP(NUM_CMP), .PSC_W(PSC_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .sys_clk_en (sys_clk_en),
    .start      (start),
    .stop       (stop),
    .clr        (clr),
    .ld         (ld),
    .ld_val     (ld_val),
    .mode       (mode),
    .period     (period),
    .psc        (psc),
    .cmp_val    (cmp_val),
    .cmp_en     (cmp_en),
    .flag_clr   (flag_clr),
    .cnt        (cnt),
    .running    (running),
    .cmp_event  (cmp_event),
    .wrap_event (wrap_event),
    .cmp_flag   (cmp_flag),
    .wrap_flag  (wrap_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // reset
    step();
    step();
    check_val("rst_cnt", 64'(cnt), 64'd0);
    check_val("rst_running", 64'(running), 64'd0);
    check_val("rst_wrap_ev", 64'(wrap_event), 64'd0);
    check_val("rst_cmp_ev", 64'(cmp_event), 64'd0);
    check_val("rst_flags", 64'({cmp_flag, wrap_flag}), 64'd0);
    sys_rst = 1'b0;
    step();

    // free-run wrap from 2^N-2
    mode = 2'b00; psc = 8'd0; ld_val = 32'hFFFF_FFFE;
    ld = 1'b1; step(); ld = 1'b0;
    check_val("fr_ld", 64'(cnt), 64'hFFFF_FFFE);
    start = 1'b1; step(); start = 1'b0;
    check_val("fr_running", 64'(running), 64'd1);
    check_val("fr_cnt_k", 64'(cnt), 64'hFFFF_FFFE);
    step();
    check_val("fr_cnt_max", 64'(cnt), 64'hFFFF_FFFF);
    check_val("fr_no_wrap", 64'(wrap_event), 64'd0);
    step();
    check_val("fr_cnt_wrap", 64'(cnt), 64'd0);
    check_val("fr_wrap_ev", 64'(wrap_event), 64'd1);
    check_val("fr_wrap_flag", 64'(wrap_flag), 64'd1);
    step();
    check_val("fr_cnt_1", 64'(cnt), 64'd1);
    check_val("fr_wrap_ev_low", 64'(wrap_event), 64'd0);
    check_val("fr_wrap_flag_sticky", 64'(wrap_flag), 64'd1);
    stop = 1'b1; step(); stop = 1'b0;
    check_val("stop_running", 64'(running), 64'd0);
    check_val("stop_cnt", 64'(cnt), 64'd1);
    step();
    check_val("stop_hold", 64'(cnt), 64'd1);

    // periodic, period 4, psc 2
    clr = 1'b1; flag_clr = 3'b111; step(); clr = 1'b0; flag_clr = 3'b000;
    check_val("clr_cnt", 64'(cnt), 64'd0);
    check_val("wrap_flag_cleared", 64'(wrap_flag), 64'd0);
    mode = 2'b01; period = 32'd4; psc = 8'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      step();
      check_val($sformatf("per_cnt_%0d", j), 64'(cnt), 64'((j / 3) % 5));
      check_val($sformatf("per_wrap_%0d", j), 64'(wrap_event), 64'((j % 15) == 0));
    end
    stop = 1'b1; step(); stop = 1'b0;

    // one-shot, period 3
    clr = 1'b1; step(); clr = 1'b0;
    mode = 2'b10; period = 32'd3; psc = 8'd0;
    start = 1'b1; step(); start = 1'b0;
    check_val("os_running", 64'(running), 64'd1);
    check_val("os_cnt0", 64'(cnt), 64'd0);
    step();
    check_val("os_cnt1", 64'(cnt), 64'd1);
    step();
    check_val("os_cnt2", 64'(cnt), 64'd2);
    step();
    check_val("os_cnt3", 64'(cnt), 64'd3);
    check_val("os_wrap_ev", 64'(wrap_event), 64'd1);
    check_val("os_done", 64'(running), 64'd0);
    step();
    check_val("os_hold", 64'(cnt), 64'd3);
    check_val("os_wrap_ev_low", 64'(wrap_event), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    check_val("os_restart_cnt", 64'(cnt), 64'd0);
    check_val("os_restart_run", 64'(running), 64'd1);
    step();
    check_val("os_restart_cnt1", 64'(cnt), 64'd1);
    stop = 1'b1; step(); stop = 1'b0;

    // compare channels
    clr = 1'b1; flag_clr = 3'b111; step(); clr = 1'b0; flag_clr = 3'b000;
    mode = 2'b00; psc = 8'd0; cmp_val = {32'd5, 32'd5}; cmp_en = 2'b01;
    start = 1'b1; step(); start = 1'b0;
    for (int j = 1; j <= 4; j++) step();
    check_val("cmp_cnt4", 64'(cnt), 64'd4);
    check_val("cmp_ev_before", 64'(cmp_event), 64'd0);
    flag_clr = 3'b001; step(); flag_clr = 3'b000;
    check_val("cmp_cnt5", 64'(cnt), 64'd5);
    check_val("cmp_ev", 64'(cmp_event), 64'b01);
    check_val("cmp_flag_set_wins", 64'(cmp_flag), 64'b01);
    step();
    check_val("cmp_ev_low", 64'(cmp_event), 64'd0);
    check_val("cmp_flag_sticky", 64'(cmp_flag), 64'b01);
    flag_clr = 3'b001; step(); flag_clr = 3'b000;
    check_val("cmp_flag_cleared", 64'(cmp_flag), 64'd0);
    check_val("cmp_cnt7", 64'(cnt), 64'd7);
    sys_clk_en = 1'b0; step(); step();
    check_val("clk_en_freeze", 64'(cnt), 64'd7);
    sys_clk_en = 1'b1; step();
    check_val("clk_en_resume", 64'(cnt), 64'd8);
    stop = 1'b1; step(); stop = 1'b0;

    // simultaneous pulses
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check_val("start_stop", 64'(running), 64'd0);
    ld_val = 32'd7; clr = 1'b1; ld = 1'b1; step(); clr = 1'b0; ld = 1'b0;
    check_val("clr_ld", 64'(cnt), 64'd0);
    ld = 1'b1; step(); ld = 1'b0;
    check_val("ld_only", 64'(cnt), 64'd7);

    // async reset mid-run
    clr = 1'b1; step(); clr = 1'b0;
    cmp_val = {32'd0, 32'd9}; cmp_en = 2'b01;
    start = 1'b1; step(); start = 1'b0;
    for (int j = 1; j <= 9; j++) step();
    check_val("pre_rst_cnt", 64'(cnt), 64'd9);
    check_val("pre_rst_cmp_ev", 64'(cmp_event), 64'b01);
    #2 sys_rst = 1'b1;
    #1;
    check_val("arst_cnt", 64'(cnt), 64'd0);
    check_val("arst_running", 64'(running), 64'd0);
    check_val("arst_events", 64'({cmp_event, wrap_event}), 64'd0);
    check_val("arst_flags", 64'({cmp_flag, wrap_flag}), 64'd0);
    step();
    sys_rst = 1'b0;
    for (int j = 1; j <= 3; j++) step();
    check_val("post_rst_cnt", 64'(cnt), 64'd0);
    check_val("post_rst_running", 64'(running), 64'd0);
    start = 1'b1; step(); start = 1'b0;
    step();
    check_val("post_rst_count", 64'(cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
